// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter sizing helper.
package serial_arith_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit-counter width: clog2 of the operand width, never narrower than 1.
    function automatic int unsigned cnt_bits(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if import serial_arith_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             zero_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, diff_o, borrow_o, zero_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, diff_o, borrow_o, zero_o
    );

endinterface

// File: rtl/serial_subtractor_btn_edge_sync.sv
// Push-button front end: 2-flop synchronizer for an active-low raw button
// plus a falling-edge detector producing one pulse per press.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Synchronize the button and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_btn_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first, single borrow flop)
// with a start/busy/done handshake and registered results.
// Optional macro BTN_SYNC_EN: start_i is a raw active-low push button,
// synchronized and falling-edge detected before it can start an operation.
module serial_subtractor import serial_arith_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);

    localparam int unsigned CW = cnt_bits(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_borrow;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;

    logic             w_start;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_work_next;
    logic             w_busy;
    logic             w_done;

`ifdef BTN_SYNC_EN
    btn_edge_sync u_btn_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn_n (bus.start_i),
        .o_fall  (w_start)
    );
`else
    assign w_start = bus.start_i;
`endif

    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    assign w_d         = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next   = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_work_next = {w_d, r_work[WIDTH-1:1]};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last)  w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_busy = (r_state == ST_SHIFT) || (r_state == ST_DONE);
        w_done = (r_state == ST_DONE);
    end

    // Datapath: operand capture, serial subtraction and result registers.
    // Results load on the final SHIFT edge (the edge that enters DONE) so they
    // are already valid while done_o is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_work   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sa  <= bus.a_i;
                        r_sb  <= bus.b_i;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_sa   <= r_sa >> 1;
                    r_sb   <= r_sb >> 1;
                    r_br   <= w_br_next;
                    r_work <= w_work_next;
                    if (w_last) begin
                        r_diff   <= w_work_next;
                        r_borrow <= w_br_next;
                        r_zero   <= (w_work_next == '0);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o   = w_busy;
    assign bus.done_o   = w_done;
    assign bus.diff_o   = r_diff;
    assign bus.borrow_o = r_borrow;
    assign bus.zero_o   = r_zero;

endmodule
